// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF packet arbiter: channel count, FSM states
// and the packet-length code decoder.
package mcdf_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  // Length code to word count; codes above 3 saturate at the FIFO depth.
  function automatic logic [3:0] len_decode(input logic [2:0] code);
    logic [3:0] len;
    case (code)
      3'd0:    len = 4'd1;
      3'd1:    len = 4'd2;
      3'd2:    len = 4'd4;
      default: len = 4'd8;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcdf_rr_pick.sv
// Combinational channel picker: lowest priority value wins among eligible
// channels, ties broken round-robin starting after the last granted channel.
module mcdf_rr_pick
  import mcdf_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [5:0] prio,
  input  logic [1:0] last_gnt,
  output logic       any_gnt,
  output logic [1:0] gnt_id
);

  logic [1:0] p [NUM_CH];
  logic [1:0] best_p;
  logic [1:0] cand;
  logic       found;

  // Unpack the per-channel priority fields.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      p[i] = prio[2*i +: 2];
    end
  end

  // Walk the channels in rotation order; a strict compare keeps the first
  // candidate in rotation order on a tie, which is the round-robin winner.
  always_comb begin
    any_gnt = |elig;
    gnt_id  = '0;
    best_p  = '1;
    found   = 1'b0;
    cand    = last_gnt;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (elig[cand] && (!found || (p[cand] < best_p))) begin
        found  = 1'b1;
        best_p = p[cand];
        gnt_id = cand;
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF packet scheduler: selects one eligible slave channel per packet and
// streams its FIFO words to the formatter, popping the FIFO on each accepted word.
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              ch_en,
  input  logic [5:0]              ch_prio,
  input  logic [8:0]              ch_len,
  input  logic [3*CNT_WIDTH-1:0]  ch_cnt,
  input  logic [3*DATA_WIDTH-1:0] ch_data,
  output logic [2:0]              ch_pop,
  output logic                    fmt_valid,
  input  logic                    fmt_ready,
  output logic [DATA_WIDTH-1:0]   fmt_data,
  output logic [1:0]              fmt_ch_id,
  output logic [3:0]              fmt_len,
  output logic                    fmt_start,
  output logic                    fmt_end,
  output logic                    busy
);

  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [3:0] len_q, len_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [1:0] last_gnt_q, last_gnt_d;

  logic [CNT_WIDTH-1:0]  cnt_a  [NUM_CH];
  logic [DATA_WIDTH-1:0] data_a [NUM_CH];
  logic [3:0]            dlen   [NUM_CH];
  logic [2:0]            elig;
  logic                  any_gnt;
  logic [1:0]            pick_id;

  // Per-channel field extraction and eligibility (enabled and a full packet queued).
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_a[i]  = ch_cnt[i*CNT_WIDTH +: CNT_WIDTH];
      data_a[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
      dlen[i]   = len_decode(ch_len[3*i +: 3]);
      elig[i]   = ch_en[i] && (32'(cnt_a[i]) >= 32'(dlen[i]));
    end
  end

  mcdf_rr_pick u_pick (
    .elig     (elig),
    .prio     (ch_prio),
    .last_gnt (last_gnt_q),
    .any_gnt  (any_gnt),
    .gnt_id   (pick_id)
  );

  // State, grant, length, word counter and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      last_gnt_q <= 2'd2;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Next-state logic and per-word handshake outputs.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    last_gnt_d = last_gnt_q;
    fmt_valid  = 1'b0;
    fmt_start  = 1'b0;
    fmt_end    = 1'b0;
    ch_pop     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_gnt) begin
          state_d    = ARB_XFER;
          gnt_d      = pick_id;
          len_d      = dlen[pick_id];
          wcnt_d     = '0;
          last_gnt_d = pick_id;
        end
      end
      ARB_XFER: begin
        fmt_valid = 1'b1;
        fmt_start = (wcnt_q == 4'd0);
        fmt_end   = (wcnt_q == (len_q - 4'd1));
        if (fmt_ready) begin
          ch_pop = 3'b001 << gnt_q;
          wcnt_d = wcnt_q + 4'd1;
          if (fmt_end) begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Head-word mux of the granted FIFO; zero outside a packet.
  always_comb begin
    fmt_data = '0;
    if (state_q == ARB_XFER) begin
      case (gnt_q)
        2'd0:    fmt_data = data_a[0];
        2'd1:    fmt_data = data_a[1];
        2'd2:    fmt_data = data_a[2];
        default: fmt_data = '0;
      endcase
    end
  end

  assign fmt_ch_id = gnt_q;
  assign fmt_len   = len_q;
  assign busy      = (state_q == ARB_XFER);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter. The bench plays the three show-ahead
// FIFOs (queues) and keeps a packet-level reference model of the scheduler.
module tb_mcdf_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      ch_en;
  logic [5:0]      ch_prio;
  logic [8:0]      ch_len;
  logic [3*CW-1:0] ch_cnt;
  logic [3*DW-1:0] ch_data;
  logic [2:0]      ch_pop;
  logic            fmt_valid;
  logic            fmt_ready;
  logic [DW-1:0]   fmt_data;
  logic [1:0]      fmt_ch_id;
  logic [3:0]      fmt_len;
  logic            fmt_start;
  logic            fmt_end;
  logic            busy;

  always #5 clk = ~clk;

  mcdf_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .ch_prio(ch_prio), .ch_len(ch_len),
    .ch_cnt(ch_cnt), .ch_data(ch_data), .ch_pop(ch_pop), .fmt_valid(fmt_valid),
    .fmt_ready(fmt_ready), .fmt_data(fmt_data), .fmt_ch_id(fmt_ch_id),
    .fmt_len(fmt_len), .fmt_start(fmt_start), .fmt_end(fmt_end), .busy(busy)
  );

  logic [DW-1:0] q [3][$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: current packet (channel, length, words sent) and RR pointer.
  int m_busy, m_ch, m_len, m_wcnt, m_last;

  function automatic int dec(input int code);
    return (code >= 3) ? 8 : (1 << code);
  endfunction

  task automatic m_reset();
    m_busy = 0; m_ch = 0; m_len = 0; m_wcnt = 0; m_last = 2;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < 3; i++) begin
      ch_cnt[i*CW +: CW]  = CW'(q[i].size());
      ch_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input int n);
    repeat (n) if (q[ch].size() < 8) q[ch].push_back($urandom);
    drive_fifo();
  endtask

  task automatic set_len(input int c0, input int c1, input int c2);
    ch_len = {3'(c2), 3'(c1), 3'(c0)};
  endtask

  // Expected {valid,start,end,busy,pop[2:0]} from the model.
  function automatic logic [6:0] exp_flags();
    logic [2:0] p;
    p = '0;
    if (m_busy != 0 && fmt_ready) p = 3'(1 << m_ch);
    return {m_busy != 0, m_busy != 0 && m_wcnt == 0, m_busy != 0 && m_wcnt == m_len - 1,
            m_busy != 0, p};
  endfunction

  function automatic logic [DW-1:0] exp_data();
    if (m_busy == 0 || q[m_ch].size() == 0) return '0;
    return q[m_ch][0];
  endfunction

  // Advance one clock: the FIFOs react to the DUT's pops, the model to the
  // inputs seen just before the edge.
  task automatic clk_step();
    logic [2:0] pop_s, en_s;
    logic       rdy_s, rst_s;
    logic [5:0] pr_s;
    logic [8:0] ln_s;
    int         c_cnt [3];
    int         best, best_p, c, pc;
    pop_s = ch_pop; rdy_s = fmt_ready; rst_s = rst;
    en_s = ch_en; pr_s = ch_prio; ln_s = ch_len;
    for (int i = 0; i < 3; i++) c_cnt[i] = q[i].size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (pop_s[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (rst_s) begin
      m_reset();
    end else if (m_busy == 0) begin
      best = -1; best_p = 4;
      for (int k = 1; k <= 3; k++) begin
        c  = (m_last + k) % 3;
        pc = int'(pr_s[2*c +: 2]);
        if (en_s[c] && c_cnt[c] >= dec(int'(ln_s[3*c +: 3])) && pc < best_p) begin
          best = c; best_p = pc;
        end
      end
      if (best >= 0) begin
        m_busy = 1; m_ch = best; m_len = dec(int'(ln_s[3*best +: 3]));
        m_wcnt = 0; m_last = best;
      end
    end else if (rdy_s) begin
      m_wcnt++;
      if (m_wcnt == m_len) m_busy = 0;
    end
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 3; i++) q[i].delete();
    drive_fifo();
    rst = 1'b1; m_reset();
    repeat (2) clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_reset();
    ch_en = '0; ch_prio = '0; ch_len = '0; fmt_ready = 1'b1;
    drive_fifo();
    @(negedge clk);
    #1;
    n_checks++;
    if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop, fmt_ch_id, fmt_len} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=0", {fmt_valid, fmt_start, fmt_end, busy, ch_pop, fmt_ch_id, fmt_len});
    end
    n_checks++;
    if (fmt_data !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", fmt_data);
    end
    apply_reset();
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] want [$];
    int words, pops;
    apply_reset();
    ch_en = 3'b001; ch_prio = '0; set_len(2, 0, 0); fmt_ready = 1'b1;
    push(0, 4);
    want = q[0];
    words = 0; pops = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      n_checks++;
      if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop} !== exp_flags()) begin
        n_fail++; $display("FAIL single_flags cyc=%0d got=%b exp=%b", cyc, {fmt_valid, fmt_start, fmt_end, busy, ch_pop}, exp_flags());
      end
      if (fmt_valid && fmt_ready && words < 4) begin
        n_checks++;
        if (fmt_data !== want[words] || fmt_start !== (words == 0) || fmt_end !== (words == 3)) begin
          n_fail++; $display("FAIL single_word w=%0d got=%h/%b%b exp=%h/%b%b", words, fmt_data, fmt_start, fmt_end, want[words], words == 0, words == 3);
        end
        words++;
      end
      if (ch_pop[0]) pops++;
      clk_step();
    end
    #1;
    n_checks++;
    if (pops != 4 || busy !== 1'b0 || q[0].size() != 0) begin
      n_fail++; $display("FAIL single_end pops=%0d busy=%b left=%0d exp pops=4 busy=0 left=0", pops, busy, q[0].size());
    end
  endtask

  task automatic test_grant_order(input string name, input logic [5:0] prio, input int nexp, input int exp_ids [9]);
    int ids [$];
    logic prev_valid;
    apply_reset();
    ch_en = 3'b111; ch_prio = prio; set_len(0, 0, 0); fmt_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(i, 8);
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 80 && ids.size() < nexp; cyc++) begin
      #1;
      n_checks++;
      if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop} !== exp_flags() || fmt_data !== exp_data()) begin
        n_fail++; $display("FAIL %s_cycle cyc=%0d got=%b/%h exp=%b/%h", name, cyc, {fmt_valid, fmt_start, fmt_end, busy, ch_pop}, fmt_data, exp_flags(), exp_data());
      end
      if (fmt_valid && fmt_start) begin
        n_checks++;
        if (prev_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s_gap pkt=%0d prev_valid=%b exp=0", name, ids.size(), prev_valid);
        end
        ids.push_back(int'(fmt_ch_id));
      end
      prev_valid = fmt_valid;
      clk_step();
    end
    n_checks++;
    if (ids.size() != nexp) begin
      n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, ids.size(), nexp);
    end
    for (int i = 0; i < ids.size(); i++) begin
      n_checks++;
      if (ids[i] != exp_ids[i]) begin
        n_fail++; $display("FAIL %s_id pkt=%0d got=%0d exp=%0d", name, i, ids[i], exp_ids[i]);
      end
    end
  endtask

  task automatic test_len_boundary();
    int words;
    apply_reset();
    ch_en = 3'b001; ch_prio = '0; set_len(3, 0, 0); fmt_ready = 1'b1;
    push(0, 7);
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      n_checks++;
      if (fmt_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL len7_nogrant cyc=%0d valid=%b busy=%b exp 0/0", cyc, fmt_valid, busy);
      end
      clk_step();
    end
    push(0, 1);
    #1;
    n_checks++;
    if (fmt_valid !== 1'b0) begin
      n_fail++; $display("FAIL len8_early valid=%b exp=0", fmt_valid);
    end
    clk_step();
    #1;
    n_checks++;
    if (fmt_valid !== 1'b1 || fmt_len !== 4'd8 || fmt_start !== 1'b1) begin
      n_fail++; $display("FAIL len8_latency valid=%b len=%0d start=%b exp 1/8/1", fmt_valid, fmt_len, fmt_start);
    end
    // Code 6 must saturate to 8 words as well.
    set_len(6, 0, 0);
    words = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      n_checks++;
      if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop} !== exp_flags() || fmt_data !== exp_data()) begin
        n_fail++; $display("FAIL len_drain cyc=%0d got=%b/%h exp=%b/%h", cyc, {fmt_valid, fmt_start, fmt_end, busy, ch_pop}, fmt_data, exp_flags(), exp_data());
      end
      if (fmt_valid && fmt_start && cyc > 0) begin
        n_checks++;
        if (fmt_len !== 4'd8) begin
          n_fail++; $display("FAIL len_sat got=%0d exp=8", fmt_len);
        end
      end
      if (fmt_valid && fmt_ready) words++;
      if (cyc == 10) push(0, 8);
      clk_step();
    end
    n_checks++;
    if (words != 16) begin
      n_fail++; $display("FAIL len_words got=%0d exp=16", words);
    end
  endtask

  task automatic test_stall();
    int words;
    logic stalled;
    logic [DW-1:0] held;
    apply_reset();
    ch_en = 3'b100; ch_prio = '0; set_len(0, 0, 3); fmt_ready = 1'b1;
    push(2, 8);
    words = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (fmt_valid && words == 4 && !stalled) begin
        stalled = 1'b1; held = fmt_data; fmt_ready = 1'b0; ch_en = 3'b000;
        repeat (3) begin
          #1;
          n_checks++;
          if (ch_pop !== 3'b000 || fmt_valid !== 1'b1 || fmt_data !== held) begin
            n_fail++; $display("FAIL stall_hold pop=%b valid=%b data=%h exp 000/1/%h", ch_pop, fmt_valid, fmt_data, held);
          end
          clk_step();
        end
        fmt_ready = 1'b1;
        #1;
      end
      n_checks++;
      if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop} !== exp_flags() || fmt_data !== exp_data()) begin
        n_fail++; $display("FAIL stall_cycle cyc=%0d got=%b/%h exp=%b/%h", cyc, {fmt_valid, fmt_start, fmt_end, busy, ch_pop}, fmt_data, exp_flags(), exp_data());
      end
      if (fmt_valid && fmt_ready) words++;
      clk_step();
    end
    n_checks++;
    if (words != 8 || busy !== 1'b0 || q[2].size() != 0) begin
      n_fail++; $display("FAIL stall_done words=%0d busy=%b left=%0d exp 8/0/0", words, busy, q[2].size());
    end
  endtask

  task automatic test_reset_mid();
    int words;
    logic done, seen;
    logic [DW-1:0] head;
    apply_reset();
    ch_en = 3'b001; ch_prio = '0; set_len(2, 0, 0); fmt_ready = 1'b1;
    push(0, 6);
    words = 0; done = 1'b0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      #1;
      if (fmt_valid && words == 2) begin
        rst = 1'b1; m_reset();
        #1;
        n_checks++;
        if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop, fmt_ch_id, fmt_len} !== '0 || fmt_data !== '0) begin
          n_fail++; $display("FAIL rstmid_outputs got=%b/%h exp=0", {fmt_valid, fmt_start, fmt_end, busy, ch_pop, fmt_ch_id, fmt_len}, fmt_data);
        end
        clk_step();
        #1;
        n_checks++;
        if (ch_pop !== 3'b000 || q[0].size() != 4) begin
          n_fail++; $display("FAIL rstmid_nopop pop=%b left=%0d exp 000/4", ch_pop, q[0].size());
        end
        rst = 1'b0;
        done = 1'b1;
      end else begin
        if (fmt_valid && fmt_ready) words++;
        clk_step();
      end
    end
    head = q[0][0];
    seen = 1'b0;
    for (int cyc = 0; cyc < 5 && !seen; cyc++) begin
      #1;
      if (fmt_valid) begin
        seen = 1'b1;
        n_checks++;
        if (fmt_ch_id !== 2'd0 || fmt_data !== head || fmt_start !== 1'b1) begin
          n_fail++; $display("FAIL rstmid_regrant id=%0d data=%h start=%b exp 0/%h/1", fmt_ch_id, fmt_data, fmt_start, head);
        end
      end
      clk_step();
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL rstmid_timeout seen=0 exp=1");
    end
  endtask

  task automatic test_random();
    apply_reset();
    ch_en = 3'b111; ch_prio = '0; set_len(0, 1, 2);
    for (int cyc = 0; cyc < 600; cyc++) begin
      fmt_ready = ($urandom_range(0, 3) != 0);
      if (cyc % 16 == 0) begin
        ch_en   = 3'($urandom_range(0, 7));
        ch_prio = 6'($urandom);
        ch_len  = 9'($urandom);
      end
      for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) == 0) push(i, 1);
      #1;
      n_checks++;
      if ({fmt_valid, fmt_start, fmt_end, busy, ch_pop} !== exp_flags() || fmt_data !== exp_data() ||
          (m_busy != 0 && (fmt_ch_id !== 2'(m_ch) || fmt_len !== 4'(m_len)))) begin
        n_fail++; $display("FAIL random cyc=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", cyc, {fmt_valid, fmt_start, fmt_end, busy, ch_pop}, fmt_data, fmt_ch_id, fmt_len, exp_flags(), exp_data(), m_ch, m_len);
      end
      clk_step();
    end
  endtask

  initial begin
    int prio_ids [9];
    int rr_ids   [9];
    prio_ids = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    rr_ids   = '{0, 1, 2, 0, 1, 2, 0, 0, 0};
    rst = 1'b1; ch_en = '0; ch_prio = '0; ch_len = '0; ch_cnt = '0; ch_data = '0; fmt_ready = 1'b0;
    m_reset();
    test_reset();
    test_single_packet();
    test_grant_order("prio", 6'b10_00_01, 9, prio_ids);
    test_grant_order("rr", 6'b00_00_00, 6, rr_ids);
    test_len_boundary();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "bench time limit");
  end

endmodule
